// File: rtl/xuanbo_duotong.sv
// xuanbo_duotong: glitch-free waveform channel selector with amplitude scaling.
// Picks one of N offset-binary waveform channels, defers channel changes to the
// next phase-accumulator wrap (or a forced switch after a timeout), then scales
// the selected sample around midscale by an 8.8 amplitude factor.
module xuanbo_duotong #(
    parameter int W       = 10,
    parameter int N       = 4,
    parameter int SW      = 3,
    parameter int TIMEOUT = 4096
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N*W-1:0]    din,
    input  logic              din_vld,
    input  logic              guoling,
    input  logic [SW-1:0]     xuanze,
    input  logic              xuanze_qingqiu,
    input  logic [8:0]        fudu,
    output logic [W-1:0]      boxin,
    output logic              boxin_vld,
    output logic [SW-1:0]     dangqian,
    output logic              mang,
    output logic              cuowu
);

    localparam logic STATE_RUN  = 1'b0;
    localparam logic STATE_WAIT = 1'b1;

    // The timer only ever needs to reach TIMEOUT-1, after which it saturates.
    localparam int              TW       = $clog2(TIMEOUT);
    localparam logic [TW-1:0]   TLAST    = TW'(TIMEOUT - 1);
    localparam logic [SW:0]     NCH      = (SW + 1)'(N);
    localparam logic [W:0]      MID_EXT  = (W + 1)'(2 ** (W - 1));
    localparam logic [W-1:0]    MID_OUT  = W'(2 ** (W - 1));

    // Product width: (W+1)-bit signed sample times 10-bit non-negative amplitude.
    localparam int                    PW    = W + 11;
    localparam logic signed [PW-1:0]  RND   = PW'(128);
    localparam logic signed [PW-1:0]  MIDP  = PW'(2 ** (W - 1));
    localparam logic signed [PW-1:0]  MAXP  = PW'(2 ** W - 1);
    localparam logic signed [PW-1:0]  ZEROP = '0;

    logic                   state;
    logic [SW-1:0]          target;
    logic [TW-1:0]          timer;

    logic signed [W:0]      s1;
    logic                   s1_vld;

    logic                   req_ok;
    logic                   req_bad;
    logic                   cancel;
    logic                   switch_now;
    logic [SW-1:0]          next_target;
    logic [SW-1:0]          eff_chan;
    logic [W-1:0]           sel_sample;
    logic signed [W:0]      s1_next;
    logic [8:0]             amp;
    logic signed [PW-1:0]   prod;
    logic signed [PW-1:0]   rounded;
    logic signed [PW-1:0]   scaled;
    logic [W-1:0]           boxin_next;

    // Request decoding and the switch decision; a switch in this cycle already
    // routes this cycle's sample from the new channel.
    always_comb begin
        req_ok      = xuanze_qingqiu && ({1'b0, xuanze} < NCH);
        req_bad     = xuanze_qingqiu && !({1'b0, xuanze} < NCH);
        cancel      = (state == STATE_WAIT) && req_ok && (xuanze == dangqian);
        next_target = (req_ok && (xuanze != dangqian)) ? xuanze : target;
        switch_now  = (state == STATE_WAIT) && !cancel && din_vld &&
                      (guoling || (timer == TLAST));
        eff_chan    = switch_now ? next_target : dangqian;
    end

    // Channel multiplexer and conversion of the chosen sample to signed form.
    always_comb begin
        sel_sample = '0;
        for (int k = 0; k < N; k++) begin
            if (eff_chan == SW'(k)) begin
                sel_sample = din[k*W +: W];
            end
        end
        s1_next = $signed({1'b0, sel_sample} - MID_EXT);
    end

    // Amplitude scaling with round-half-up, re-centering and clamping.
    always_comb begin
        amp     = (fudu > 9'd256) ? 9'd256 : fudu;
        prod    = $signed({{10{s1[W]}}, s1}) * $signed({{(W + 2){1'b0}}, amp});
        rounded = (prod + RND) >>> 8;
        scaled  = rounded + MIDP;
        if (scaled < ZEROP) begin
            boxin_next = '0;
        end else if (scaled > MAXP) begin
            boxin_next = MAXP[W-1:0];
        end else begin
            boxin_next = scaled[W-1:0];
        end
    end

    // Channel-switch FSM: RUN routes the current channel, WAIT holds a pending
    // target until a qualified wrap or the timeout forces the change.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= STATE_RUN;
            target   <= '0;
            timer    <= '0;
            dangqian <= '0;
        end else begin
            case (state)
                STATE_RUN: begin
                    if (req_ok && (xuanze != dangqian)) begin
                        target <= xuanze;
                        timer  <= '0;
                        state  <= STATE_WAIT;
                    end
                end
                STATE_WAIT: begin
                    if (cancel) begin
                        state <= STATE_RUN;
                    end else if (switch_now) begin
                        dangqian <= next_target;
                        state    <= STATE_RUN;
                    end else begin
                        target <= next_target;
                        if (timer != TLAST) begin
                            timer <= timer + TW'(1);
                        end
                    end
                end
                default: begin
                    state <= STATE_RUN;
                end
            endcase
        end
    end

    // Sticky flag for requests naming a channel that does not exist.
    always_ff @(posedge clk) begin
        if (rst) begin
            cuowu <= 1'b0;
        end else if (req_bad) begin
            cuowu <= 1'b1;
        end
    end

    // Stage 1: capture the selected sample relative to midscale.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1     <= '0;
            s1_vld <= 1'b0;
        end else begin
            s1_vld <= din_vld;
            if (din_vld) begin
                s1 <= s1_next;
            end
        end
    end

    // Stage 2: publish the scaled sample; the output holds through gaps.
    always_ff @(posedge clk) begin
        if (rst) begin
            boxin     <= MID_OUT;
            boxin_vld <= 1'b0;
        end else begin
            boxin_vld <= s1_vld;
            if (s1_vld) begin
                boxin <= boxin_next;
            end
        end
    end

    assign mang = (state == STATE_WAIT);

endmodule

// File: doc/xuanbo_duotong.md
XUANBO_DUOTONG -- requirements
Module: xuanbo_duotong

Interface
REQ-001 Parameter W, default 10, sample width (offset-binary, midscale 2^(W-1)).
REQ-002 Parameter N, default 4, number of waveform channels (0=cos, 1=sin, 2=fangbo, 3=sanjiaobo, further channels user-defined), 2..16.
REQ-003 Parameter SW, default 3, select width; SW SHALL satisfy 2^SW >= N.
REQ-004 Parameter TIMEOUT, default 4096, forced-switch cycle count, >= 2.
REQ-005 clk  input  1  sole clock; all logic on rising edge.
REQ-006 rst  input  1  synchronous, active-high reset.
REQ-007 din  input  N*W  packed channel samples; channel k at bits [k*W+W-1 : k*W].
REQ-008 din_vld  input  1  samples valid this cycle.
REQ-009 guoling  input  1  phase-accumulator wrap pulse, qualified by din_vld.
REQ-010 xuanze  input  SW  requested channel.
REQ-011 xuanze_qingqiu  input  1  request strobe, one cycle.
REQ-012 fudu  input  9  amplitude, 256 = unity.
REQ-013 boxin  output  W  scaled selected waveform.
REQ-014 boxin_vld  output  1  boxin valid.
REQ-015 dangqian  output  SW  channel currently routed.
REQ-016 mang  output  1  switch pending (state WAIT).
REQ-017 cuowu  output  1  sticky flag: request with xuanze >= N seen.

Function
REQ-018 FSM states SHALL be RUN and WAIT; mang = (state == WAIT).
REQ-019 RUN: strobe with xuanze < N and xuanze != dangqian -> latch target, clear timer, go WAIT; xuanze == dangqian -> ignored.
REQ-020 Any strobe with xuanze >= N SHALL be ignored for routing and SHALL set cuowu; dangqian holds.
REQ-021 WAIT: a new valid strobe SHALL overwrite target and SHALL NOT restart the timer; strobe equal to dangqian SHALL cancel, returning to RUN.
REQ-022 WAIT: din_vld & guoling -> dangqian <= target, go RUN; the sample of that same cycle SHALL already use the new channel.
REQ-023 WAIT: timer increments every clock; on reaching TIMEOUT-1 without a wrap, switch SHALL be forced at the next din_vld cycle (or immediately if din_vld that cycle).
REQ-024 Strobe and guoling in the same RUN cycle: the switch SHALL wait for the next wrap.
REQ-025 Stage 1 (on din_vld): register s = selected sample - 2^(W-1), signed W+1 bits, with the effective channel.
REQ-026 Stage 2: p = s * min(fudu,256); boxin = ((p + 128) >>> 8) + 2^(W-1), clamped to [0, 2^W-1].
REQ-027 Latency SHALL be exactly 2 cycles din_vld -> boxin_vld; boxin_vld SHALL be 1 only for valid samples; gaps pass through unchanged.
REQ-028 fudu SHALL be sampled in stage 2 of each sample; fudu > 256 SHALL act as 256; fudu = 0 SHALL give midscale.
REQ-029 boxin SHALL hold its last value while boxin_vld = 0.

Reset
REQ-030 rst SHALL force boxin = 2^(W-1), boxin_vld = 0, dangqian = 0, state RUN, mang = 0, cuowu = 0, timer 0, pipeline valids 0.
REQ-031 rst mid-WAIT SHALL discard the pending target; in-flight samples SHALL be dropped (no boxin_vld after reset release until new din_vld + 2).

Verification (W=10, N=4, TIMEOUT=16)
REQ-032 Reset, din_vld=1 continuously, cos=700, fudu=256 -> boxin=700 from cycle 2 after first din_vld, dangqian=0.
REQ-033 fudu=128, sample 900 -> boxin=((388*128+128)>>8)+512 = 706; sample 100, fudu=128 -> 306; fudu=0 -> 512; fudu=400, sample 1023 -> 1023.
REQ-034 Strobe xuanze=2 mid-period -> mang=1, boxin still from cos; at wrap cycle boxin (2 cycles later) from fangbo, dangqian=2, mang=0.
REQ-035 Strobe xuanze=3, no guoling for 16 cycles -> forced switch, dangqian=3, mang=0.
REQ-036 Strobe xuanze=5 -> cuowu=1, dangqian unchanged, mang unchanged.
REQ-037 WAIT then rst asserted one cycle -> dangqian=0, mang=0, boxin=512, boxin_vld=0 for 2 cycles after din_vld resumes.
